uart_tx_bins: RTL and testbench



---
 rtl/uart_bins_pkg.sv | 7 +
 rtl/uart_tx_fifo_bins.sv | 45 ++++
 rtl/uart_tx_bins.sv | 113 +++++++++++
 tb/tb_uart_tx_bins.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_bins_pkg.sv
// uart_bins_pkg: shared UART frame constants and FSM state encoding (used by tx and rx)
package uart_bins_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  localparam int DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
endpackage

// File: rtl/uart_tx_fifo_bins.sv
// uart_tx_fifo_bins: byte FIFO; ports clk, rst (async high), push/din in, pop/dout out, full/empty flags
module uart_tx_fifo_bins #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  always_comb begin
    full = count_q == CW'(FIFO_DEPTH);
    empty = count_q == '0;
    do_push = push && !full;
    do_pop = pop && !empty;
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    dout = mem[rd_q];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_q] <= din;
endmodule

// File: rtl/uart_tx_bins.sv
// uart_tx_bins: buffered odd-parity UART transmitter; clockIN/txResetIN, txValidIN/txDataIN/txReadyOUT handshake, txOUT line, txBusyOUT
module uart_tx_bins
  import uart_bins_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int PARITY_ODD = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clockIN,
  input  logic       txResetIN,
  input  logic       txValidIN,
  input  logic [7:0] txDataIN,
  output logic       txReadyOUT,
  output logic       txOUT,
  output logic       txBusyOUT
);
  localparam int BAUD_DIV = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CW = (BAUD_DIV < 2) ? 1 : $clog2(BAUD_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(BAUD_DIV - 1);
  if (BAUD_DIV < 2) begin : g_bad_baud
    $error("BAUD_DIV must be >= 2");
  end
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d, dout;
  logic [2:0] idx_q, idx_d;
  logic tx_q, tx_d, busy_q, busy_d;
  logic push, pop, full, empty, bit_end;
  assign push = txValidIN && !full;
  assign txReadyOUT = !full;
  assign txOUT = tx_q;
  assign txBusyOUT = busy_q;
  uart_tx_fifo_bins #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clockIN),
    .rst(txResetIN),
    .push(push),
    .pop(pop),
    .din(txDataIN),
    .dout(dout),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    bit_end = cnt_q == '0;
    state_d = state_q;
    cnt_d = bit_end ? cnt_q : cnt_q - CW'(1);
    data_d = data_q;
    idx_d = idx_q;
    tx_d = tx_q;
    pop = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop = 1'b1;
        data_d = dout;
        tx_d = START_BIT;
        cnt_d = RELOAD;
        state_d = START;
      end
      START: if (bit_end) begin
        tx_d = data_q[0];
        idx_d = '0;
        cnt_d = RELOAD;
        state_d = DATA;
      end
      DATA: if (bit_end) begin
        cnt_d = RELOAD;
        if (idx_q == 3'(DATA_BITS - 1)) begin
          tx_d = (PARITY_ODD != 0) ? ~^data_q : STOP_BIT;
          state_d = (PARITY_ODD != 0) ? PARITY : STOP;
        end else begin
          idx_d = idx_q + 3'd1;
          tx_d = data_q[idx_q + 3'd1];
        end
      end
      PARITY: if (bit_end) begin
        tx_d = STOP_BIT;
        cnt_d = RELOAD;
        state_d = STOP;
      end
      STOP: if (bit_end) begin
        if (!empty) begin
          pop = 1'b1;
          data_d = dout;
          tx_d = START_BIT;
          cnt_d = RELOAD;
          state_d = START;
        end else begin
          tx_d = STOP_BIT;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) || !empty;
  end
  always_ff @(posedge clockIN or posedge txResetIN)
    if (txResetIN) begin
      state_q <= IDLE;
      cnt_q <= '0;
      data_q <= '0;
      idx_q <= '0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      idx_q <= idx_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
    end
endmodule

// File: tb/tb_uart_tx_bins.sv
// tb_uart_tx_bins: randomized self-checking bench against a frame-level UART model
module tb_uart_tx_bins;
  logic clk = 1'b0, rst = 1'b1;
  logic valid_a = 1'b0, valid_b = 1'b0;
  logic [7:0] data_a = '0, data_b = '0;
  logic rdy_a, tx_a, busy_a, rdy_b, tx_b, busy_b;
  int cyc = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  uart_tx_bins #(.CLOCK_FREQUENCY(1_000_000), .BAUD_RATE(100_000), .PARITY_ODD(1), .FIFO_DEPTH(4)) dut_a (
    .clockIN(clk), .txResetIN(rst), .txValidIN(valid_a), .txDataIN(data_a),
    .txReadyOUT(rdy_a), .txOUT(tx_a), .txBusyOUT(busy_a));
  uart_tx_bins #(.CLOCK_FREQUENCY(1_000_000), .BAUD_RATE(100_000), .PARITY_ODD(0), .FIFO_DEPTH(4)) dut_b (
    .clockIN(clk), .txResetIN(rst), .txValidIN(valid_b), .txDataIN(data_b),
    .txReadyOUT(rdy_b), .txOUT(tx_b), .txBusyOUT(busy_b));
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic exp_bit(input logic [7:0] b, input int k, input bit nopar);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[3'(k - 1)];
    if (k == 9 && !nopar) return ($countones(b) % 2) == 0;
    return 1'b1;
  endfunction
  task automatic send(input bit nopar, input logic [7:0] b);
    int n = 0;
    if (nopar) begin data_b = b; valid_b = 1'b1; end
    else begin data_a = b; valid_a = 1'b1; end
    while (!(nopar ? rdy_b : rdy_a) && n < 500) begin tick(); n++; end
    checks++;
    if (n >= 500) begin errors++; $display("FAIL send_timeout byte=%02h got=ready_low exp=ready_high", b); end
    tick();
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask
  task automatic wait_fall(input bit nopar, input string nm);
    int n = 0;
    while ((nopar ? tx_b : tx_a) !== 1'b0 && n < 300) begin tick(); n++; end
    checks++;
    if (n >= 300) begin errors++; $display("FAIL %s start_timeout got=no_start exp=start_bit", nm); end
  endtask
  task automatic check_frame(input logic [7:0] b, input bit nopar, input string nm);
    int nb = nopar ? 10 : 11;
    logic obs;
    repeat (5) tick();
    for (int k = 0; k < nb; k++) begin
      obs = nopar ? tx_b : tx_a;
      checks++;
      if (obs !== exp_bit(b, k, nopar)) begin
        errors++;
        $display("FAIL %s bit%0d byte=%02h got=%b exp=%b", nm, k, b, obs, exp_bit(b, k, nopar));
      end
      if (k == 0) begin
        checks++;
        if ((nopar ? busy_b : busy_a) !== 1'b1) begin errors++; $display("FAIL %s busy_mid got=0 exp=1", nm); end
      end
      if (k < nb - 1) repeat (10) tick();
    end
    repeat (5) tick();
  endtask
  task automatic check_idle(input string nm);
    checks++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || rdy_a !== 1'b1) begin
      errors++;
      $display("FAIL %s idle got=tx%b busy%b rdy%b exp=tx1 busy0 rdy1", nm, tx_a, busy_a, rdy_a);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    check_idle("in_reset");
    checks++;
    if (tx_b !== 1'b1 || busy_b !== 1'b0 || rdy_b !== 1'b1) begin errors++; $display("FAIL reset_b got=tx%b busy%b rdy%b exp=tx1 busy0 rdy1", tx_b, busy_b, rdy_b); end
    rst = 1'b0;
    repeat (3) tick();
    check_idle("after_reset");
  endtask
  task automatic test_single();
    send(1'b0, 8'h55);
    checks++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL single_pre got=tx%b busy%b exp=tx1 busy0", tx_a, busy_a); end
    tick();
    checks++;
    if (tx_a !== 1'b0) begin errors++; $display("FAIL single_latency got=%b exp=0", tx_a); end
    check_frame(8'h55, 1'b0, "single");
    check_idle("single_end");
  endtask
  task automatic test_parity();
    logic [7:0] bytes [8];
    bytes = '{8'h00, 8'h07, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 4; i < 8; i++) bytes[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      send(1'b0, bytes[i]);
      wait_fall(1'b0, "parity");
      check_frame(bytes[i], 1'b0, "parity");
      check_idle("parity_end");
    end
  endtask
  task automatic test_burst();
    logic [7:0] q [$];
    int f0 = 0;
    for (int i = 0; i < 6; i++) q.push_back(8'hA0 + 8'(i));
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(1'b0, q[i]);
          if (i == 3) begin
            checks++;
            if (rdy_a !== 1'b1) begin errors++; $display("FAIL burst_ready3 got=%b exp=1", rdy_a); end
          end
          if (i == 4) begin
            checks++;
            if (rdy_a !== 1'b0) begin errors++; $display("FAIL burst_full got=%b exp=0", rdy_a); end
          end
        end
      end
      begin
        wait_fall(1'b0, "burst");
        f0 = cyc;
        for (int i = 0; i < 6; i++) begin
          if (i > 0) begin
            checks++;
            if (tx_a !== 1'b0) begin errors++; $display("FAIL burst_gap frame%0d got=%b exp=0", i, tx_a); end
          end
          check_frame(q[i], 1'b0, "burst");
        end
        checks++;
        if (cyc - f0 != 660) begin errors++; $display("FAIL burst_len got=%0d exp=660", cyc - f0); end
        check_idle("burst_end");
      end
    join
  endtask
  task automatic test_reset_mid();
    int f;
    int bad = 0;
    send(1'b0, 8'h3C);
    f = cyc + 1;
    send(1'b0, 8'($urandom));
    send(1'b0, 8'($urandom));
    while (cyc < f + 35) tick();
    rst = 1'b1;
    #1;
    check_idle("reset_mid");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset_mid_quiet got=%0d_active_cycles exp=0", bad); end
  endtask
  task automatic test_push_pop();
    logic [7:0] b1 = 8'($urandom), b2 = 8'($urandom);
    int f = 0;
    fork
      begin
        send(1'b0, b1);
        send(1'b0, b2);
        f = cyc;
        while (cyc < f + 109) tick();
        data_a = 8'h11;
        valid_a = 1'b1;
        checks++;
        if (rdy_a !== 1'b1) begin errors++; $display("FAIL pushpop_ready got=%b exp=1", rdy_a); end
        tick();
        valid_a = 1'b0;
        checks++;
        if (rdy_a !== 1'b1) begin errors++; $display("FAIL pushpop_after got=%b exp=1", rdy_a); end
      end
      begin
        wait_fall(1'b0, "pushpop");
        check_frame(b1, 1'b0, "pushpop1");
        check_frame(b2, 1'b0, "pushpop2");
        check_frame(8'h11, 1'b0, "pushpop3");
        check_idle("pushpop_end");
      end
    join
  endtask
  task automatic test_no_parity();
    int f;
    send(1'b1, 8'h81);
    tick();
    f = cyc;
    checks++;
    if (tx_b !== 1'b0) begin errors++; $display("FAIL nopar_latency got=%b exp=0", tx_b); end
    check_frame(8'h81, 1'b1, "nopar");
    checks++;
    if (busy_b !== 1'b0 || tx_b !== 1'b1 || cyc - f != 100) begin
      errors++;
      $display("FAIL nopar_end got=busy%b tx%b len%0d exp=busy0 tx1 len100", busy_b, tx_b, cyc - f);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_parity();
    test_burst();
    test_reset_mid();
    test_push_pop();
    test_no_parity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
